// File: rtl/avr_io_intc.sv
// rtl/avr_io_intc.sv - latched, maskable 4-line interrupt controller on the AVR I/O bus
//
// Purpose: captures peripheral requests as edge- or level-sensitive pending
// bits, masks them and presents a registered iflag/ivect pair to the core.
// Edge-pending bits clear on ack or W1C write to IPEND.
// Optional feature macro: AVR_INTC_SYNC_EN (two-flop synchronizer on irq).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   io_re, io_we        pre-qualified I/O read / write strobes
//   io_a                register select (0 IPEND, 1 IMASK, 2 IMODE, 3 IVEC)
//   io_di               read data to core, 8'h00 when io_re is low (wired-OR)
//   io_do               write data from core
//   irq                 raw request lines, bit 0 highest priority
//   ack, ack_vect       core has taken vector ack_vect
//   iflag, ivect        registered interrupt request / vector to core

module avr_io_intc #(
  parameter logic [3:0] RESET_MASK = 4'h0,
  parameter logic [3:0] RESET_MODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [1:0] io_a,
  output logic [7:0] io_di,
  input  logic [7:0] io_do,
  input  logic [3:0] irq,
  input  logic       ack,
  input  logic [1:0] ack_vect,
  output logic       iflag,
  output logic [1:0] ivect
);

  logic [3:0] pend_q, pend_d;
  logic [3:0] ovr_q,  ovr_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] mode_q, mode_d;
  logic [3:0] p_q,    p_d;
  logic       iflag_q, iflag_d;
  logic [1:0] ivect_q, ivect_d;
  logic [3:0] s;
  logic [3:0] rise;
  logic [3:0] masked;
  logic       wr_pend;

`ifdef AVR_INTC_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  // Marks when sync2_q holds a real irq sample rather than its reset zero.
  // Until then p_q is held at its reset value so a line high through reset
  // does not look like a fresh rising edge once the synchronizer fills.
  logic [1:0] sync_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 4'h0;
      sync2_q   <= 4'h0;
      sync_ok_q <= 2'b00;
    end else begin
      sync1_q   <= irq;
      sync2_q   <= sync1_q;
      sync_ok_q <= {sync_ok_q[0], 1'b1};
    end
  end

  assign s   = sync2_q;
  assign p_d = sync_ok_q[1] ? s : p_q;
`else
  assign s   = irq;
  assign p_d = s;
`endif

  assign rise    = s & ~p_q;
  assign wr_pend = io_we && (io_a == 2'd0);
  assign masked  = pend_q & mask_q;

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < 4; i++) begin
      if (mode_q[i]) begin
        // A new edge beats any clear in the same cycle, and since the bit
        // stays set nothing was lost, so overrun is only flagged when the
        // edge lands on an un-cleared pending bit.
        if (rise[i]) begin
          pend_d[i] = 1'b1;
          if (pend_q[i] && !((ack && (ack_vect == 2'(i))) || (wr_pend && io_do[i])))
            ovr_d[i] = 1'b1;
          else if (wr_pend && io_do[i+4])
            ovr_d[i] = 1'b0;
        end else begin
          if ((ack && (ack_vect == 2'(i))) || (wr_pend && io_do[i]))
            pend_d[i] = 1'b0;
          if (wr_pend && io_do[i+4])
            ovr_d[i] = 1'b0;
        end
      end else begin
        pend_d[i] = s[i];
        if (wr_pend && io_do[i+4])
          ovr_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (io_we && (io_a == 2'd1)) mask_d = io_do[3:0];
    if (io_we && (io_a == 2'd2)) mode_d = io_do[3:0];
  end

  always_comb begin
    iflag_d = |masked;
    ivect_d = 2'd0;
    if (masked[0])      ivect_d = 2'd0;
    else if (masked[1]) ivect_d = 2'd1;
    else if (masked[2]) ivect_d = 2'd2;
    else if (masked[3]) ivect_d = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 4'h0;
      ovr_q   <= 4'h0;
      mask_q  <= RESET_MASK;
      mode_q  <= RESET_MODE;
      p_q     <= 4'hF;
      iflag_q <= 1'b0;
      ivect_q <= 2'd0;
    end else begin
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      iflag_q <= iflag_d;
      ivect_q <= ivect_d;
    end
  end

  always_comb begin
    io_di = 8'h00;
    if (io_re) begin
      case (io_a)
        2'd0:    io_di = {ovr_q, pend_q};
        2'd1:    io_di = {4'h0, mask_q};
        2'd2:    io_di = {4'h0, mode_q};
        default: io_di = {iflag_q, 5'b0, ivect_q};
      endcase
    end
  end

  assign iflag = iflag_q;
  assign ivect = ivect_q;

endmodule

// File: tb/tb_avr_io_intc.sv
// tb/tb_avr_io_intc.sv - directed self-checking bench for avr_io_intc

module tb_avr_io_intc;

`ifdef AVR_INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [1:0] io_a = 2'd0;
  logic [7:0] io_di;
  logic [7:0] io_do = 8'h00;
  logic [3:0] irq = 4'h0;
  logic       ack = 1'b0;
  logic [1:0] ack_vect = 2'd0;
  logic       iflag;
  logic [1:0] ivect;

  int total = 0;
  int bad = 0;
  logic [7:0] d;

  always #5 clk = ~clk;

  avr_io_intc dut (
    .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
    .io_di(io_di), .io_do(io_do), .irq(irq), .ack(ack), .ack_vect(ack_vect),
    .iflag(iflag), .ivect(ivect)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    io_a = a;
    io_re = 1'b1;
    #1;
    v = io_di;
    io_re = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    io_a = a;
    io_do = v;
    io_we = 1'b1;
    cyc(1);
    io_we = 1'b0;
    io_do = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    irq = 4'hF;
    cyc(3);
    rst = 1'b0;
    cyc(LAT + 3);
    total++; if (iflag !== 1'b0) begin $display("FAIL reset_iflag got=%0h exp=0", iflag); bad++; end
    total++; if (ivect !== 2'd0) begin $display("FAIL reset_ivect got=%0h exp=0", ivect); bad++; end
    rd(2'd0, d);
    total++; if (d !== 8'h00) begin $display("FAIL reset_ipend got=%02h exp=00", d); bad++; end
    rd(2'd1, d);
    total++; if (d !== 8'h00) begin $display("FAIL reset_imask got=%02h exp=00", d); bad++; end
    rd(2'd2, d);
    total++; if (d !== 8'h0F) begin $display("FAIL reset_imode got=%02h exp=0f", d); bad++; end
  endtask

  task automatic test_priority;
    wr(2'd1, 8'h0F);
    irq = 4'h0;
    cyc(LAT + 2);
    irq = 4'b1010;
    cyc(1);
    irq = 4'h0;
    cyc(LAT);
    rd(2'd0, d);
    total++; if (d !== 8'h0A) begin $display("FAIL prio_ipend got=%02h exp=0a", d); bad++; end
    total++; if (iflag !== 1'b0) begin $display("FAIL prio_iflag_latency got=%0h exp=0", iflag); bad++; end
    cyc(1);
    total++; if (iflag !== 1'b1) begin $display("FAIL prio_iflag got=%0h exp=1", iflag); bad++; end
    total++; if (ivect !== 2'd1) begin $display("FAIL prio_ivect got=%0h exp=1", ivect); bad++; end
    ack = 1'b1; ack_vect = 2'd1;
    cyc(1);
    ack = 1'b0;
    rd(2'd0, d);
    total++; if (d !== 8'h08) begin $display("FAIL ack1_ipend got=%02h exp=08", d); bad++; end
    total++; if (ivect !== 2'd1) begin $display("FAIL ack1_stale_ivect got=%0h exp=1", ivect); bad++; end
    cyc(1);
    total++; if (ivect !== 2'd3) begin $display("FAIL ack1_ivect got=%0h exp=3", ivect); bad++; end
    ack = 1'b1; ack_vect = 2'd3;
    cyc(1);
    ack = 1'b0;
    cyc(1);
    total++; if (iflag !== 1'b0) begin $display("FAIL ack3_iflag got=%0h exp=0", iflag); bad++; end
  endtask

  task automatic test_overrun;
    irq = 4'h4; cyc(1);
    irq = 4'h0; cyc(1);
    irq = 4'h4; cyc(1);
    irq = 4'h0; cyc(LAT + 1);
    rd(2'd0, d);
    total++; if (d !== 8'h44) begin $display("FAIL ovr_ipend got=%02h exp=44", d); bad++; end
    ack = 1'b1; ack_vect = 2'd0;
    cyc(1);
    ack = 1'b0;
    rd(2'd0, d);
    total++; if (d !== 8'h44) begin $display("FAIL ack_idle_vect got=%02h exp=44", d); bad++; end
    wr(2'd0, 8'h40);
    rd(2'd0, d);
    total++; if (d !== 8'h04) begin $display("FAIL w1c_ovr got=%02h exp=04", d); bad++; end
    wr(2'd0, 8'h04);
    rd(2'd0, d);
    total++; if (d !== 8'h00) begin $display("FAIL w1c_pend got=%02h exp=00", d); bad++; end
    cyc(2);
  endtask

  task automatic test_level;
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h01);
    irq = 4'h1;
    cyc(LAT + 2);
    total++; if (iflag !== 1'b1) begin $display("FAIL lvl_iflag got=%0h exp=1", iflag); bad++; end
    ack = 1'b1; ack_vect = 2'd0;
    cyc(1);
    ack = 1'b0;
    cyc(1);
    total++; if (iflag !== 1'b1) begin $display("FAIL lvl_ack_iflag got=%0h exp=1", iflag); bad++; end
    wr(2'd0, 8'h01);
    rd(2'd0, d);
    total++; if (d !== 8'h01) begin $display("FAIL lvl_w1c_ignored got=%02h exp=01", d); bad++; end
    irq = 4'h0;
    cyc(LAT + 1);
    rd(2'd0, d);
    total++; if (d !== 8'h00) begin $display("FAIL lvl_drop_ipend got=%02h exp=00", d); bad++; end
    total++; if (iflag !== 1'b1) begin $display("FAIL lvl_drop_stale got=%0h exp=1", iflag); bad++; end
    cyc(1);
    total++; if (iflag !== 1'b0) begin $display("FAIL lvl_drop_iflag got=%0h exp=0", iflag); bad++; end
    wr(2'd2, 8'h0F);
    cyc(1);
  endtask

  task automatic test_mask_bus;
    wr(2'd1, 8'h00);
    irq = 4'h1; cyc(1);
    irq = 4'h0; cyc(LAT);
    rd(2'd0, d);
    total++; if (d !== 8'h01) begin $display("FAIL mask_ipend got=%02h exp=01", d); bad++; end
    cyc(1);
    total++; if (iflag !== 1'b0) begin $display("FAIL mask_iflag got=%0h exp=0", iflag); bad++; end
    rd(2'd3, d);
    total++; if (d !== 8'h00) begin $display("FAIL mask_ivec got=%02h exp=00", d); bad++; end
    wr(2'd1, 8'h01);
    rd(2'd3, d);
    total++; if (d !== 8'h00) begin $display("FAIL unmask_ivec_early got=%02h exp=00", d); bad++; end
    cyc(1);
    rd(2'd3, d);
    total++; if (d !== 8'h80) begin $display("FAIL unmask_ivec got=%02h exp=80", d); bad++; end
    wr(2'd3, 8'hFF);
    rd(2'd3, d);
    total++; if (d !== 8'h80) begin $display("FAIL ivec_write_ignored got=%02h exp=80", d); bad++; end
    for (int a = 0; a < 4; a++) begin
      io_a = 2'(a);
      io_re = 1'b0;
      #1;
      total++; if (io_di !== 8'h00) begin $display("FAIL bus_idle a=%0d got=%02h exp=00", a, io_di); bad++; end
    end
    wr(2'd0, 8'h01);
    cyc(2);
  endtask

  task automatic test_conflict;
    irq = 4'h1; cyc(1);
    irq = 4'h0; cyc(LAT + 1);
    rd(2'd0, d);
    total++; if (d !== 8'h01) begin $display("FAIL cfl_setup got=%02h exp=01", d); bad++; end
    irq = 4'h1;
    cyc(LAT);
    ack = 1'b1; ack_vect = 2'd0;
    cyc(1);
    ack = 1'b0;
    irq = 4'h0;
    rd(2'd0, d);
    total++; if (d !== 8'h01) begin $display("FAIL cfl_ack_edge got=%02h exp=01", d); bad++; end
    cyc(LAT + 1);
    irq = 4'h1;
    cyc(LAT);
    ack = 1'b1; ack_vect = 2'd0;
    io_we = 1'b1; io_a = 2'd0; io_do = 8'h01;
    cyc(1);
    ack = 1'b0; io_we = 1'b0; io_do = 8'h00;
    irq = 4'h0;
    rd(2'd0, d);
    total++; if (d !== 8'h01) begin $display("FAIL cfl_ack_w1c_edge got=%02h exp=01", d); bad++; end
    cyc(LAT + 1);
    ack = 1'b1; ack_vect = 2'd0;
    io_we = 1'b1; io_a = 2'd0; io_do = 8'h01;
    cyc(1);
    ack = 1'b0; io_we = 1'b0; io_do = 8'h00;
    rd(2'd0, d);
    total++; if (d !== 8'h00) begin $display("FAIL cfl_ack_w1c_clear got=%02h exp=00", d); bad++; end
    cyc(1);
    total++; if (iflag !== 1'b0) begin $display("FAIL cfl_iflag got=%0h exp=0", iflag); bad++; end
  endtask

  task automatic test_reset_mid;
    irq = 4'h2; cyc(1);
    irq = 4'h0; cyc(LAT + 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    rd(2'd0, d);
    total++; if (d !== 8'h00) begin $display("FAIL midrst_ipend got=%02h exp=00", d); bad++; end
    total++; if (iflag !== 1'b0) begin $display("FAIL midrst_iflag got=%0h exp=0", iflag); bad++; end
  endtask

  initial begin
    cyc(1);
    test_reset;
    test_priority;
    test_overrun;
    test_level;
    test_mask_bus;
    test_conflict;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
